// File: rtl/pool_line_buffer.sv
// Row-pair line buffer feeding a 2x2 stride-2 max-pool stage; flags window-capture cycles.
// Optional POOL_COORD_EN adds pool_col/pool_row window coordinates alongside pool_take.
module pool_line_buffer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned IMG_WIDTH  = 28,
    parameter int unsigned IMG_HEIGHT = 28,
    parameter int unsigned POOL_LAT   = 2
`ifdef POOL_COORD_EN
    ,
    parameter int unsigned PCOL_W = (IMG_WIDTH / 2 > 1) ? $clog2(IMG_WIDTH / 2) : 1,
    parameter int unsigned PROW_W = (IMG_HEIGHT / 2 > 1) ? $clog2(IMG_HEIGHT / 2) : 1
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] pix_in,
    input  logic                  pix_valid,
    output logic [DATA_WIDTH-1:0] line_1,
    output logic [DATA_WIDTH-1:0] line_2,
    output logic                  line_valid,
    output logic                  pool_take,
    output logic                  busy,
    output logic                  frame_done,
`ifdef POOL_COORD_EN
    output logic [PCOL_W-1:0]     pool_col,
    output logic [PROW_W-1:0]     pool_row,
`endif
    output logic                  err
);

    localparam int unsigned COL_W = $clog2(IMG_WIDTH);
    localparam int unsigned ROW_W = $clog2(IMG_HEIGHT);
    localparam int unsigned DRN_W = $clog2(POOL_LAT + 1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        STREAM,
        DRAIN
    } state_t;

    state_t                  state;
    logic [COL_W-1:0]        col;
    logic [ROW_W-1:0]        row;
    logic [DRN_W-1:0]        drn_cnt;
    logic [POOL_LAT-1:0]     take_sr;
    logic [DATA_WIDTH-1:0]   ram [IMG_WIDTH];

    logic active_c;
    logic accept_c;
    logic last_col_c;
    logic last_row_c;
    logic win_c;

    assign active_c   = (state == FILL) || (state == STREAM);
    assign accept_c   = active_c && pix_valid;
    assign last_col_c = (col == COL_W'(IMG_WIDTH - 1));
    assign last_row_c = (row == ROW_W'(IMG_HEIGHT - 1));
    // A beat at odd row and odd col closes a 2x2 window; odd trailing col/row never qualify.
    assign win_c      = (state == STREAM) && pix_valid && col[0] && row[0];

    // Row store: read of RAM[col] below sees the previous row before this write lands.
    always_ff @(posedge clk) begin
        if (accept_c) begin
            ram[col] <= pix_in;
        end
    end

    // Frame FSM, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            col        <= '0;
            row        <= '0;
            drn_cnt    <= '0;
            take_sr    <= '0;
            line_1     <= '0;
            line_2     <= '0;
            line_valid <= 1'b0;
            pool_take  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            line_valid <= 1'b0;
            frame_done <= 1'b0;
            take_sr[0] <= win_c;
            for (int i = 1; i < int'(POOL_LAT); i++) begin
                take_sr[i] <= take_sr[i-1];
            end
            pool_take <= take_sr[POOL_LAT-1];

            case (state)
                IDLE: begin
                    if (start) begin
                        state <= FILL;
                        busy  <= 1'b1;
                        err   <= 1'b0;
                        col   <= '0;
                        row   <= '0;
                    end
                end
                FILL, STREAM: begin
                    if (pix_valid) begin
                        if (state == STREAM) begin
                            line_1     <= ram[col];
                            line_2     <= pix_in;
                            line_valid <= 1'b1;
                        end
                        if (last_col_c) begin
                            col <= '0;
                            if (last_row_c && (state == STREAM)) begin
                                state   <= DRAIN;
                                drn_cnt <= '0;
                            end else begin
                                row   <= row + ROW_W'(1);
                                state <= STREAM;
                            end
                        end else begin
                            col <= col + COL_W'(1);
                        end
                    end else if (col != '0) begin
                        err <= 1'b1;
                    end
                end
                DRAIN: begin
                    // frame_done lands in the last drain cycle, aligned with the final pool_take.
                    if (drn_cnt == DRN_W'(POOL_LAT)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        drn_cnt <= drn_cnt + DRN_W'(1);
                        if (drn_cnt == DRN_W'(POOL_LAT - 1)) begin
                            frame_done <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef POOL_COORD_EN
    logic [PCOL_W-1:0] pcol_sr [POOL_LAT];
    logic [PROW_W-1:0] prow_sr [POOL_LAT];

    // Window coordinates travel with the take pipeline and are latched as pool_take rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(POOL_LAT); i++) begin
                pcol_sr[i] <= '0;
                prow_sr[i] <= '0;
            end
            pool_col <= '0;
            pool_row <= '0;
        end else begin
            pcol_sr[0] <= PCOL_W'(col >> 1);
            prow_sr[0] <= PROW_W'(row >> 1);
            for (int i = 1; i < int'(POOL_LAT); i++) begin
                pcol_sr[i] <= pcol_sr[i-1];
                prow_sr[i] <= prow_sr[i-1];
            end
            if (take_sr[POOL_LAT-1]) begin
                pool_col <= pcol_sr[POOL_LAT-1];
                pool_row <= prow_sr[POOL_LAT-1];
            end
        end
    end
`endif

endmodule
